// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC memory-side bus blocks: master IDs and default widths.
package soc_bus_pkg;

    typedef enum logic {
        MST_CPU = 1'b0,
        MST_AUX = 1'b1
    } mst_id_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int OUTST_DEF  = 4;

    function automatic mst_id_t other_mst(input mst_id_t id);
        return (id == MST_CPU) ? MST_AUX : MST_CPU;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// Small synchronous FIFO with full/empty/count, used to track owners of in-order responses.
module id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only read after being written, and
    // leaving it out lets the array map onto plain flops or LUT RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dmem_arbiter2.sv
// Round-robin two-master arbiter for the data-memory/MMIO port, with grant lock under
// back-pressure and an owner FIFO routing in-order responses back to the issuer.
module dmem_arbiter2
    import soc_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OUTST  = OUTST_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic                m0_req_we,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_be,
    output logic                m0_rsp_valid,
    output logic [DATA_W-1:0]   m0_rsp_rdata,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic                m1_req_we,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_be,
    output logic                m1_rsp_valid,
    output logic [DATA_W-1:0]   m1_rsp_rdata,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic                s_req_we,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_be,
    input  logic                s_rsp_valid,
    input  logic [DATA_W-1:0]   s_rsp_rdata,
    output logic                err_orphan_rsp
);
    localparam int CNT_W = $clog2(OUTST) + 1;

    mst_id_t          prio;
    mst_id_t          lock_id;
    mst_id_t          gnt;
    mst_id_t          head;
    logic             lock;
    logic             gnt_valid;
    logic             accept;
    logic             rsp_pop;
    logic             ord_full;
    logic             ord_empty;
    logic             ord_dout;
    logic [CNT_W-1:0] ord_count;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = prio;
        if (lock)                              gnt = lock_id;
        else if (m0_req_valid && !m1_req_valid) gnt = MST_CPU;
        else if (m1_req_valid && !m0_req_valid) gnt = MST_AUX;
    end

    always_comb begin
        gnt_valid   = m0_req_valid;
        s_req_we    = m0_req_we;
        s_req_addr  = m0_req_addr;
        s_req_wdata = m0_req_wdata;
        s_req_be    = m0_req_be;
        if (gnt == MST_AUX) begin
            gnt_valid   = m1_req_valid;
            s_req_we    = m1_req_we;
            s_req_addr  = m1_req_addr;
            s_req_wdata = m1_req_wdata;
            s_req_be    = m1_req_be;
        end
    end

    // A full order FIFO stalls the request exactly like downstream back-pressure.
    assign s_req_valid  = gnt_valid && !ord_full;
    assign accept       = s_req_valid && s_req_ready;
    assign m0_req_ready = (gnt == MST_CPU) && s_req_ready && !ord_full;
    assign m1_req_ready = (gnt == MST_AUX) && s_req_ready && !ord_full;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio           <= MST_CPU;
            lock           <= 1'b0;
            lock_id        <= MST_CPU;
            err_orphan_rsp <= 1'b0;
        end else begin
            if (accept) begin
                prio <= other_mst(gnt);
                lock <= 1'b0;
            end else if (gnt_valid) begin
                lock    <= 1'b1;
                lock_id <= gnt;
            end
            if (s_rsp_valid && ord_empty) err_orphan_rsp <= 1'b1;
        end
    end

    id_fifo #(
        .W     (1),
        .DEPTH (OUTST)
    ) u_order (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (gnt),
        .pop   (s_rsp_valid),
        .dout  (ord_dout),
        .full  (ord_full),
        .empty (ord_empty),
        .count (ord_count)
    );

    assign head    = mst_id_t'(ord_dout);
    assign rsp_pop = s_rsp_valid && !ord_empty;

    assign m0_rsp_valid = rsp_pop && (head == MST_CPU);
    assign m1_rsp_valid = rsp_pop && (head == MST_AUX);
    assign m0_rsp_rdata = m0_rsp_valid ? s_rsp_rdata : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? s_rsp_rdata : '0;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ord_count <= CNT_W'(OUTST));

endmodule

// File: tb/tb_dmem_arbiter2.sv
// Scoreboard bench for dmem_arbiter2: directed stimulus, downstream latency model,
// and a response monitor comparing against per-master expected-data queues.
module tb_dmem_arbiter2;
    import soc_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic [3:0]  m0_req_be;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic [3:0]  m1_req_be;
    logic        s_req_valid, s_req_ready, s_req_we, s_rsp_valid, err_orphan_rsp;
    logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
    logic [3:0]  s_req_be;

    always #5 clk = ~clk;

    dmem_arbiter2 #(.DATA_W(32), .ADDR_W(32), .OUTST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_be(m0_req_be),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_be(m1_req_be),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_be(s_req_be),
        .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
        .err_orphan_rsp(err_orphan_rsp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Downstream model: loads return {A5A5, addr[15:0]}, stores return 0, after lat cycles.
    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    pend_t       pend_q[$];
    int          lat = 1;
    bit          rsp_hold = 0;
    int          rsp_credit = 0;
    bit          inject_orphan = 0;
    int          gnt_log[$];
    int          acc_cyc[$];

    always @(negedge clk) begin
        pend_t p;
        if (rst_n && s_req_valid && s_req_ready) begin
            p.due  = cyc + lat;
            p.data = s_req_we ? 32'h0 : {16'hA5A5, s_req_addr[15:0]};
            pend_q.push_back(p);
            gnt_log.push_back(m1_req_ready ? 1 : 0);
            acc_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        #1;
        s_rsp_valid = 1'b0;
        s_rsp_rdata = '0;
        if (inject_orphan) begin
            s_rsp_valid   = 1'b1;
            s_rsp_rdata   = 32'hDEAD_BEEF;
            inject_orphan = 0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc && (!rsp_hold || rsp_credit > 0)) begin
            s_rsp_valid = 1'b1;
            s_rsp_rdata = pend_q[0].data;
            void'(pend_q.pop_front());
            if (rsp_hold) rsp_credit--;
        end
    end

    // Response monitor / scoreboard.
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          rsp_log[$];
    int          rsp_cnt[2];

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_rsp_valid) begin
                rsp_log.push_back(0);
                rsp_cnt[0]++;
                if (exp_q0.size() == 0) fail_now("m0 unexpected rsp_valid");
                else check("m0 rsp_rdata", m0_rsp_rdata, exp_q0.pop_front());
            end
            if (m1_rsp_valid) begin
                rsp_log.push_back(1);
                rsp_cnt[1]++;
                if (exp_q1.size() == 0) fail_now("m1 unexpected rsp_valid");
                else check("m1 rsp_rdata", m1_rsp_rdata, exp_q1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp);
        bit ok = 0;
        if (m == 0) begin
            m0_req_valid = 1; m0_req_we = we; m0_req_addr = addr; m0_req_wdata = wdata; m0_req_be = be;
            exp_q0.push_back(exp);
        end else begin
            m1_req_valid = 1; m1_req_we = we; m1_req_addr = addr; m1_req_wdata = wdata; m1_req_be = be;
            exp_q1.push_back(exp);
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (m == 0) ? (m0_req_valid && m0_req_ready) : (m1_req_valid && m1_req_ready);
        end
        if (!ok) fail_now($sformatf("issue timeout m%0d addr 0x%08h", m, addr));
        tick();
        if (m == 0) m0_req_valid = 0;
        else        m1_req_valid = 0;
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            idle = (exp_q0.size() == 0) && (exp_q1.size() == 0) && (pend_q.size() == 0);
        end
        if (!idle) fail_now("drain timeout");
        tick();
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        acc_cyc.delete();
        rsp_log.delete();
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
    endtask

    initial begin
        int m0_grants;
        int viol;
        bit seen;
        rst_n = 0;
        m0_req_valid = 0; m0_req_we = 0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_be = '0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_be = '0;
        s_req_ready = 0; s_rsp_valid = 0; s_rsp_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset s_req_valid", s_req_valid, 0);
        check("reset m0_rsp_valid", m0_rsp_valid, 0);
        check("reset m1_rsp_valid", m1_rsp_valid, 0);
        check("reset err_orphan_rsp", err_orphan_rsp, 0);
        rst_n = 1;
        tick();

        // T1: m0-only loads, latency 2
        clear_logs();
        lat = 2;
        s_req_ready = 1;
        issue(0, 0, 32'h100, 0, 4'hF, 32'hA5A5_0100);
        issue(0, 0, 32'h104, 0, 4'hF, 32'hA5A5_0104);
        wait_idle();
        check("t1 accepts", gnt_log.size(), 2);
        if (acc_cyc.size() == 2) check("t1 back-to-back", acc_cyc[1] - acc_cyc[0], 1);
        check("t1 m0 rsp count", rsp_cnt[0], 2);
        check("t1 m1 rsp count", rsp_cnt[1], 0);

        // T2: both masters always valid -> strict alternation
        clear_logs();
        lat = 1;
        fork
            for (int i = 0; i < 10; i++)
                issue(0, 0, 32'h1000 + 32'(i * 4), 0, 4'hF, 32'hA5A5_1000 + 32'(i * 4));
            for (int j = 0; j < 10; j++)
                issue(1, 0, 32'h2000 + 32'(j * 4), 0, 4'hF, 32'hA5A5_2000 + 32'(j * 4));
        join
        wait_idle();
        m0_grants = 0;
        viol = 0;
        for (int i = 0; i < gnt_log.size(); i++) begin
            if (gnt_log[i] == 0) m0_grants++;
            if (i > 0 && gnt_log[i] == gnt_log[i-1]) viol++;
        end
        check("t2 accepts", gnt_log.size(), 20);
        check("t2 m0 grants", m0_grants, 10);
        check("t2 alternation violations", viol, 0);
        check("t2 m1 rsp count", rsp_cnt[1], 10);

        // T3: prio=m1, both valid, downstream stalled 3 cycles
        clear_logs();
        s_req_ready = 0;
        fork
            issue(1, 0, 32'h200, 0, 4'hF, 32'hA5A5_0200);
            issue(0, 0, 32'h300, 0, 4'hF, 32'hA5A5_0300);
        join_none
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3 stall s_req_valid", s_req_valid, 1);
            check("t3 stall s_req_addr", s_req_addr, 32'h200);
            check("t3 stall m0_req_ready", m0_req_ready, 0);
        end
        tick();
        s_req_ready = 1;
        wait fork;
        wait_idle();
        check("t3 accepts", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("t3 first grant", gnt_log[0], 1);
            check("t3 second grant", gnt_log[1], 0);
        end

        // T3b: lock holds m0 although prio now favours m1
        clear_logs();
        s_req_ready = 0;
        fork
            issue(0, 0, 32'h400, 0, 4'hF, 32'hA5A5_0400);
            begin
                tick();
                issue(1, 0, 32'h500, 0, 4'hF, 32'hA5A5_0500);
            end
        join_none
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3b locked s_req_addr", s_req_addr, 32'h400);
        end
        tick();
        s_req_ready = 1;
        wait fork;
        wait_idle();
        check("t3b accepts", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("t3b first grant", gnt_log[0], 0);
            check("t3b second grant", gnt_log[1], 1);
        end

        // T4: FIFO full blocks, one m1 response frees a slot for the next cycle
        clear_logs();
        rsp_hold = 1;
        rsp_credit = 0;
        fork
            for (int i = 0; i < 5; i++)
                issue(1, 0, 32'h600 + 32'(i * 4), 0, 4'hF, 32'hA5A5_0600 + 32'(i * 4));
        join_none
        for (int i = 0; i < 50 && gnt_log.size() < 4; i++) @(negedge clk);
        check("t4 accepts before full", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4 full m1_req_ready", m1_req_ready, 0);
            check("t4 full s_req_valid", s_req_valid, 0);
        end
        rsp_credit = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = m1_rsp_valid;
        end
        if (!seen) fail_now("t4 response timeout");
        check("t4 no bypass on pop cycle", m1_req_ready, 0);
        @(negedge clk);
        check("t4 ready after pop", m1_req_ready, 1);
        rsp_hold = 0;
        wait fork;
        wait_idle();
        check("t4 total accepts", gnt_log.size(), 5);

        // T5: store from m0 then load from m1, in-order routing
        clear_logs();
        lat = 2;
        issue(0, 1, 32'h700, 32'h1234_5678, 4'h3, 32'h0);
        issue(1, 0, 32'h704, 0, 4'hF, 32'hA5A5_0704);
        wait_idle();
        check("t5 rsp count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("t5 first rsp owner", rsp_log[0], 0);
            check("t5 second rsp owner", rsp_log[1], 1);
        end

        // T6: orphan response, sticky error, async reset clears it
        @(negedge clk);
        inject_orphan = 1;
        @(negedge clk);
        check("t6 orphan m0_rsp_valid", m0_rsp_valid, 0);
        check("t6 orphan m1_rsp_valid", m1_rsp_valid, 0);
        check("t6 err before edge", err_orphan_rsp, 0);
        @(negedge clk);
        check("t6 err set", err_orphan_rsp, 1);
        repeat (5) @(negedge clk);
        check("t6 err sticky", err_orphan_rsp, 1);
        #2 rst_n = 0;
        #1;
        check("t6 err cleared by async reset", err_orphan_rsp, 0);
        @(negedge clk);
        rst_n = 1;

        check("final m0 expected queue empty", exp_q0.size(), 0);
        check("final m1 expected queue empty", exp_q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
